// File: rtl/alu_share_if.sv
// alu_share_if
//   Groups the request, response and ALU-drive signals of alu_share_ctrl.
//   The slave modport is the controller's view. The master modport is the view
//   of the surrounding requester/ALU environment.
//
//   Request side  : req_valid, req_ready, req_operand1_0/1, req_operand2_0/1,
//                   req_control_0/1
//   Response side : resp_valid, resp_ready, resp_result, resp_err
//   ALU side      : alu_operand1, alu_operand2, alu_control, alu_result
//   Status        : busy
interface alu_share_if;
    logic        [1:0] req_valid;
    logic        [1:0] req_ready;
    logic signed [3:0] req_operand1_0;
    logic signed [3:0] req_operand1_1;
    logic signed [3:0] req_operand2_0;
    logic signed [3:0] req_operand2_1;
    logic        [1:0] req_control_0;
    logic        [1:0] req_control_1;
    logic        [1:0] resp_valid;
    logic        [1:0] resp_ready;
    logic signed [7:0] resp_result;
    logic              resp_err;
    logic signed [3:0] alu_operand1;
    logic signed [3:0] alu_operand2;
    logic        [1:0] alu_control;
    logic signed [7:0] alu_result;
    logic              busy;

    modport slave (
        input  req_valid, req_operand1_0, req_operand1_1,
               req_operand2_0, req_operand2_1, req_control_0, req_control_1,
               resp_ready, alu_result,
        output req_ready, resp_valid, resp_result, resp_err,
               alu_operand1, alu_operand2, alu_control, busy
    );

    modport master (
        output req_valid, req_operand1_0, req_operand1_1,
               req_operand2_0, req_operand2_1, req_control_0, req_control_1,
               resp_ready, alu_result,
        input  req_ready, resp_valid, resp_result, resp_err,
               alu_operand1, alu_operand2, alu_control, busy
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one combinational SimpleALU between two requesters. It arbitrates
//   round-robin, drives the ALU from registers, waits SETTLE cycles and then
//   returns the captured result through a valid/ready handshake.
//
//   Parameters : SETTLE (1..15) cycles the ALU inputs are held before capture
//   Ports      : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - alu_share_if.slave (request, response, ALU drive, busy)
//   Option     : ALU_SHARE_DIV0_CHK_EN - when defined, a divide by zero bypasses
//                the ALU and answers with result 0 and resp_err = 1. When it
//                is undefined, resp_err is tied to 0.
module alu_share_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_share_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t            state_q, state_d;
    logic        [3:0] cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic        [1:0] resp_valid_q, resp_valid_d;
    logic signed [7:0] resp_result_q, resp_result_d;
    logic signed [3:0] alu_op1_q, alu_op1_d;
    logic signed [3:0] alu_op2_q, alu_op2_d;
    logic        [1:0] alu_ctrl_q, alu_ctrl_d;
    logic        [1:0] grant;
    logic              sel;
`ifdef ALU_SHARE_DIV0_CHK_EN
    logic              resp_err_q, resp_err_d;
`endif

    // Round-robin grant, offered only while IDLE. On a tie, the requester
    // that did not win last time is granted.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE) begin
            unique case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel = grant[1];

    // Next-state and datapath loads. A non-zero grant in IDLE is an accept,
    // because a grant bit is only raised where req_valid is high.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        alu_op1_d     = alu_op1_q;
        alu_op2_d     = alu_op2_q;
        alu_ctrl_d    = alu_ctrl_q;
`ifdef ALU_SHARE_DIV0_CHK_EN
        resp_err_d    = resp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    owner_d      = sel;
                    last_grant_d = sel;
                    alu_op1_d    = sel ? bus.req_operand1_1 : bus.req_operand1_0;
                    alu_op2_d    = sel ? bus.req_operand2_1 : bus.req_operand2_0;
                    alu_ctrl_d   = sel ? bus.req_control_1  : bus.req_control_0;
                    cnt_d        = SETTLE_CNT;
                    state_d      = ISSUE;
`ifdef ALU_SHARE_DIV0_CHK_EN
                    // Divide by zero is answered directly and never reaches the ALU result path.
                    if (alu_ctrl_d == 2'b11 && alu_op2_d == 4'sd0) begin
                        resp_result_d = 8'sd0;
                        resp_err_d    = 1'b1;
                        resp_valid_d  = grant;
                        state_d       = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                // A count of 1 or below also covers an illegal SETTLE of 0, which then behaves like 1.
                if (cnt_q <= 4'd1) begin
                    resp_result_d = bus.alu_result;
                    resp_valid_d  = owner_q ? 2'b10 : 2'b01;
                    state_d       = RESP;
`ifdef ALU_SHARE_DIV0_CHK_EN
                    resp_err_d    = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready[owner_q]) begin
                    resp_valid_d = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            resp_valid_q  <= 2'b00;
            resp_result_q <= 8'sd0;
            alu_op1_q     <= 4'sd0;
            alu_op2_q     <= 4'sd0;
            alu_ctrl_q    <= 2'b00;
`ifdef ALU_SHARE_DIV0_CHK_EN
            resp_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            alu_op1_q     <= alu_op1_d;
            alu_op2_q     <= alu_op2_d;
            alu_ctrl_q    <= alu_ctrl_d;
`ifdef ALU_SHARE_DIV0_CHK_EN
            resp_err_q    <= resp_err_d;
`endif
        end
    end

    assign bus.req_ready    = grant;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_result  = resp_result_q;
    assign bus.alu_operand1 = alu_op1_q;
    assign bus.alu_operand2 = alu_op2_q;
    assign bus.alu_control  = alu_ctrl_q;
    assign bus.busy         = (state_q != IDLE);
`ifdef ALU_SHARE_DIV0_CHK_EN
    assign bus.resp_err     = resp_err_q;
`else
    assign bus.resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
//   Bench for alu_share_ctrl. It drives two instances: one with SETTLE=1 and
//   one with SETTLE=3. Each instance has a behavioural SimpleALU on its
//   alu_* ports. The ALU_SHARE_DIV0_CHK_EN macro enables the divide-by-zero
//   sequence.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_share_if bus1 ();
    alu_share_if bus3 ();

    alu_share_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_share_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Behavioural SimpleALU that sits on the controller's ALU ports.
    function automatic logic signed [7:0] aluModel(input logic signed [3:0] a,
                                                   input logic signed [3:0] b,
                                                   input logic [1:0] c);
        logic signed [7:0] ea;
        logic signed [7:0] eb;
        ea = a;
        eb = b;
        case (c)
            2'b00:   return ea + eb;
            2'b01:   return ea * eb;
            2'b10:   return ea - eb;
            default: return (eb == 8'sd0) ? 8'sd0 : ea / eb;
        endcase
    endfunction

    always_comb bus1.alu_result = aluModel(bus1.alu_operand1, bus1.alu_operand2, bus1.alu_control);
    always_comb bus3.alu_result = aluModel(bus3.alu_operand1, bus3.alu_operand2, bus3.alu_control);

    typedef struct {
        logic signed [3:0] op1;
        logic signed [3:0] op2;
        logic        [1:0] ctrl;
        logic signed [7:0] expResult;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Runs one operation on requester 0 of the SETTLE=1 instance. resp_ready is held high.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        bus1.req_valid      = 2'b01;
        bus1.req_operand1_0 = v.op1;
        bus1.req_operand2_0 = v.op2;
        bus1.req_control_0  = v.ctrl;
        #1;
        checkOutput({tag, "_req_ready"}, int'(bus1.req_ready), 1);
        @(negedge clk);
        bus1.req_valid = 2'b00;
        checkOutput({tag, "_busy_issue"}, int'(bus1.busy), 1);
        checkOutput({tag, "_no_early_valid"}, int'(bus1.resp_valid), 0);
        checkOutput({tag, "_alu_op1"}, int'(bus1.alu_operand1), int'(v.op1));
        checkOutput({tag, "_alu_op2"}, int'(bus1.alu_operand2), int'(v.op2));
        checkOutput({tag, "_alu_ctrl"}, int'(bus1.alu_control), int'(v.ctrl));
        @(negedge clk);
        checkOutput({tag, "_resp_valid"}, int'(bus1.resp_valid), 1);
        checkOutput({tag, "_resp_result"}, int'(bus1.resp_result), int'(v.expResult));
        checkOutput({tag, "_resp_err"}, int'(bus1.resp_err), 0);
        @(negedge clk);
        checkOutput({tag, "_resp_done"}, int'(bus1.resp_valid), 0);
        checkOutput({tag, "_idle"}, int'(bus1.busy), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int   nGrant;
        logic lastOwner;
        logic grants[4];

        vecs[0] = '{4'sd4,  -4'sd5, 2'b00, -8'sd1};
        vecs[1] = '{-4'sd3, 4'sd7,  2'b01, -8'sd21};
        vecs[2] = '{4'sd2,  4'sd7,  2'b10, -8'sd5};
        vecs[3] = '{4'sd6,  4'sd3,  2'b11, 8'sd2};
        vecs[4] = '{4'sd5,  4'sd3,  2'b11, 8'sd1};

        rst_n = 1'b0;
        bus1.req_valid = 2'b00; bus1.resp_ready = 2'b00;
        bus1.req_operand1_0 = 4'sd0; bus1.req_operand2_0 = 4'sd0; bus1.req_control_0 = 2'b00;
        bus1.req_operand1_1 = 4'sd0; bus1.req_operand2_1 = 4'sd0; bus1.req_control_1 = 2'b00;
        bus3.req_valid = 2'b00; bus3.resp_ready = 2'b00;
        bus3.req_operand1_0 = 4'sd0; bus3.req_operand2_0 = 4'sd0; bus3.req_control_0 = 2'b00;
        bus3.req_operand1_1 = 4'sd0; bus3.req_operand2_1 = 4'sd0; bus3.req_control_1 = 2'b00;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", int'(bus1.req_ready), 0);
        checkOutput("rst_resp_valid", int'(bus1.resp_valid), 0);
        checkOutput("rst_busy", int'(bus1.busy), 0);
        checkOutput("rst_resp_result", int'(bus1.resp_result), 0);
        checkOutput("rst_resp_err", int'(bus1.resp_err), 0);
        checkOutput("rst_alu_op1", int'(bus1.alu_operand1), 0);
        checkOutput("rst_alu_op2", int'(bus1.alu_operand2), 0);
        checkOutput("rst_alu_ctrl", int'(bus1.alu_control), 0);
        checkOutput("rst3_busy", int'(bus3.busy), 0);
        rst_n = 1'b1;

        // Table of single operations with SETTLE=1
        bus1.resp_ready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // SETTLE=3, requester 1 computes -8 / -1, and the response is stalled for 4 cycles
        @(negedge clk);
        bus3.req_valid      = 2'b10;
        bus3.req_operand1_1 = -4'sd8;
        bus3.req_operand2_1 = -4'sd1;
        bus3.req_control_1  = 2'b11;
        bus3.resp_ready     = 2'b00;
        #1;
        checkOutput("s3_req_ready", int'(bus3.req_ready), 2);
        @(negedge clk);
        bus3.req_valid = 2'b01;
        bus3.req_operand1_0 = 4'sd1; bus3.req_operand2_0 = 4'sd1; bus3.req_control_0 = 2'b00;
        bus3.resp_ready = 2'b01;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("s3_wait%0d_valid", c), int'(bus3.resp_valid), 0);
            checkOutput($sformatf("s3_wait%0d_req_ready", c), int'(bus3.req_ready), 0);
            @(negedge clk);
        end
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("s3_hold%0d_valid", c), int'(bus3.resp_valid), 2);
            checkOutput($sformatf("s3_hold%0d_result", c), int'(bus3.resp_result), 8);
            checkOutput($sformatf("s3_hold%0d_req_ready", c), int'(bus3.req_ready), 0);
            if (c == 3) bus3.resp_ready = 2'b11;
            @(negedge clk);
        end
        checkOutput("s3_done_valid", int'(bus3.resp_valid), 0);
        checkOutput("s3_nonowner_granted", int'(bus3.req_ready), 1);
        bus3.req_valid  = 2'b00;
        bus3.resp_ready = 2'b00;

        // Both requesters valid continuously from reset: grants must alternate
        doReset();
        bus1.req_operand1_0 = 4'sd1; bus1.req_operand2_0 = 4'sd1; bus1.req_control_0 = 2'b00;
        bus1.req_operand1_1 = 4'sd3; bus1.req_operand2_1 = 4'sd3; bus1.req_control_1 = 2'b00;
        bus1.resp_ready = 2'b11;
        bus1.req_valid  = 2'b11;
        nGrant = 0;
        lastOwner = 1'b0;
        for (int cyc = 0; cyc < 30 && nGrant < 4; cyc++) begin
            #1;
            if (bus1.req_ready != 2'b00) begin
                checkOutput("alt_onehot", int'(bus1.req_ready == 2'b11), 0);
                grants[nGrant] = bus1.req_ready[1];
                lastOwner = bus1.req_ready[1];
                nGrant++;
            end
            if (bus1.resp_valid != 2'b00) begin
                checkOutput("alt_route", int'(bus1.resp_valid), lastOwner ? 2 : 1);
                checkOutput("alt_result", int'(bus1.resp_result), lastOwner ? 6 : 2);
            end
            if (nGrant < 4) @(negedge clk);
        end
        bus1.req_valid = 2'b00;
        checkOutput("alt_grant_count", nGrant, 4);
        for (int g = 0; g < 4 && g < nGrant; g++) begin
            checkOutput($sformatf("alt_grant%0d", g), int'(grants[g]), g % 2);
        end

`ifdef ALU_SHARE_DIV0_CHK_EN
        // Divide by zero skips ISSUE and responds with an error
        @(negedge clk);
        bus1.req_valid      = 2'b01;
        bus1.req_operand1_0 = 4'sd7;
        bus1.req_operand2_0 = 4'sd0;
        bus1.req_control_0  = 2'b11;
        @(negedge clk);
        bus1.req_valid = 2'b00;
        checkOutput("div0_valid", int'(bus1.resp_valid), 1);
        checkOutput("div0_result", int'(bus1.resp_result), 0);
        checkOutput("div0_err", int'(bus1.resp_err), 1);
        @(negedge clk);
        checkOutput("div0_done", int'(bus1.resp_valid), 0);
        applyStimulus('{4'sd7, 4'sd1, 2'b11, 8'sd7}, "div1");
`endif

        // Reset pulse during ISSUE discards the operation
        @(negedge clk);
        bus1.req_valid      = 2'b01;
        bus1.req_operand1_0 = 4'sd3;
        bus1.req_operand2_0 = 4'sd2;
        bus1.req_control_0  = 2'b00;
        @(negedge clk);
        bus1.req_valid = 2'b00;
        checkOutput("rp_in_issue", int'(bus1.busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rp_busy", int'(bus1.busy), 0);
        checkOutput("rp_resp_valid", int'(bus1.resp_valid), 0);
        checkOutput("rp_resp_result", int'(bus1.resp_result), 0);
        checkOutput("rp_alu_op1", int'(bus1.alu_operand1), 0);
        checkOutput("rp_alu_op2", int'(bus1.alu_operand2), 0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rp_no_response", int'(bus1.resp_valid), 0);
        checkOutput("rp_still_idle", int'(bus1.busy), 0);
        applyStimulus('{4'sd3, 4'sd2, 2'b00, 8'sd5}, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing controller that shares one combinational `SimpleALU` (signed 4-bit operands, 2-bit control, signed 8-bit result) between two independent requesters. It sits between the requester logic and the ALU instance:
- arbitrates round-robin;
- drives the ALU operand and control ports from registers;
- waits a configurable settle time, then captures the result;
- returns the result to the owning requester through a valid/ready handshake.

## Interface
- `SETTLE`, default 1, number of cycles the ALU inputs are held before the result is captured (legal range 1..15).
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid[1:0]`  in  2  request valid; bit i belongs to requester i.
- `req_ready[1:0]`  out  2  request accepted when `req_valid[i] & req_ready[i]`.
- `req_operand1_0`, `req_operand1_1`  in  4 each  signed first operand per requester.
- `req_operand2_0`, `req_operand2_1`  in  4 each  signed second operand per requester.
- `req_control_0`, `req_control_1`  in  2 each  operation: 00 add, 01 mul, 10 sub (op1−op2), 11 div (op1/op2, truncation toward zero).
- `resp_valid[1:0]`  out  2  response valid for requester i.
- `resp_ready[1:0]`  in  2  response consumed when `resp_valid[i] & resp_ready[i]`.
- `resp_result`  out  8  signed result, shared by both requesters; qualified by `resp_valid`.
- `resp_err`  out  1  divide-by-zero flag, qualified by `resp_valid`.
- `alu_operand1`, `alu_operand2`  out  4 each  registered drive to the ALU `operand1`/`operand2`.
- `alu_control`  out  2  registered drive to the ALU `control`.
- `alu_result`  in  8  ALU `result` input.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM with three states: IDLE, ISSUE, RESP.
- **IDLE, arbitration.** The controller grants one requester per cycle.
  - Only one `req_valid` high: that requester gets `req_ready`.
  - Both high: the requester other than `last_grant` gets `req_ready`.
  - `req_ready` is 0 in every state except IDLE, and at most one bit is ever high.
- **IDLE, acceptance.** On an accepted request:
  - operands and control are latched into the `alu_*` registers;
  - `owner` and `last_grant` are set to the granted index;
  - the settle counter is loaded with `SETTLE`;
  - the FSM moves to ISSUE.
- **ISSUE.**
  - `alu_*` registers are held stable.
  - The counter decrements each cycle.
  - On the edge where the counter equals 1: `alu_result` is captured into `resp_result`, `resp_err` is cleared, `resp_valid[owner]` is set, and the FSM moves to RESP.
- **RESP.**
  - `resp_valid[owner]`, `resp_result` and `resp_err` are held until `resp_ready[owner]`.
  - On that edge `resp_valid` clears and the FSM moves to IDLE.
  - `resp_ready` of the non-owner is ignored.
- **Between operations.** `alu_*` registers keep their last value; they change only on acceptance.
- **Arithmetic.** The result is the ALU output passed through unmodified. The controller performs no width conversion.

## Timing
- **Reset values:**
  - `req_ready`, `resp_valid`, `busy` = 0;
  - `resp_result` = 0, `resp_err` = 0;
  - `alu_operand1`, `alu_operand2`, `alu_control` = 0;
  - state IDLE, `last_grant` = 1, so requester 0 wins the first tie.
- **Latency.** `resp_valid` rises `SETTLE` cycles after the accept edge.
- **Throughput.** Best case is one operation per `SETTLE`+2 cycles, with immediate `resp_ready`. IDLE always lasts at least one cycle.
- **`resp_ready` already high** when `resp_valid` rises: the response completes on the next edge.
- **Requester drops `req_valid` while not granted:** no effect.
- **Non-owner holds `req_valid` throughout an operation:** it is granted in the next IDLE cycle (no starvation).
- **`rst_n` low mid-operation:** all state clears immediately, the in-flight operation is discarded and no response is issued.

## Configuration
- **`ALU_SHARE_DIV0_CHK_EN` defined:**
  - An accepted request with control 11 and operand2 = 0 skips ISSUE.
  - On the next edge: `resp_result` = 0, `resp_err` = 1, `resp_valid[owner]` = 1, FSM to RESP.
  - The `alu_*` registers are still loaded.
- **`ALU_SHARE_DIV0_CHK_EN` undefined:**
  - No check; division by zero follows the normal ISSUE path and the result is whatever the ALU produces.
  - `resp_err` is constant 0.
  - Benches must not check the division-by-zero result in this build.

## Test plan
- **Single operations, requester 0, `SETTLE`=1, `resp_ready` held high.** Each row is operands, op → `resp_result`, with `resp_valid[0]` one cycle after accept:

  | operand1 | operand2 | op | `resp_result` |
  |---|---|---|---|
  | 4 | −5 | add | −1 |
  | −3 | 7 | mul | −21 |
  | 2 | 7 | sub | −5 |
  | 6 | 3 | div | 2 |
  | 5 | 3 | div | 1 |

- **Both requesters valid continuously from reset** → grants alternate 0,1,0,1. Responses are routed only to the matching `resp_valid` bit.
- **`SETTLE`=3; requester 1: −8 / −1; `resp_ready[1]` low for 4 cycles** → `resp_valid[1]` rises 3 cycles after accept, with `resp_result` 8 held stable until ready. `req_ready` stays 0 meanwhile.
- **`ALU_SHARE_DIV0_CHK_EN` defined; request 7 / 0** → next cycle `resp_valid`=1, `resp_result`=0, `resp_err`=1. A following 7 / 1 returns 7 with `resp_err`=0.
- **`rst_n` pulsed low during ISSUE** → all outputs return to reset values asynchronously, with no response. A subsequent request from requester 0 completes normally.
